// File: rtl/tt_um_gate_arb.sv
// tt_um_gate_arb: four requesters share one 2-input logic unit (AND/OR/XOR/NAND)
// under round-robin arbitration, with a per-grant watchdog and a sticky error flag.
`default_nettype none

module tt_um_gate_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] WD_MAX = 4'd15;

  state_t     state, state_nx;
  logic [1:0] ptr, ptr_nx;
  logic [1:0] idx, idx_nx;
  logic [1:0] op, op_nx;
  logic       a, a_nx;
  logic       b, b_nx;
  logic       result, result_nx;
  logic [3:0] wd, wd_nx;
  logic       err, err_nx;

  logic [3:0] req;
  logic       hold;
  logic       found;
  logic [1:0] win;
  logic [1:0] cand;
  logic       unused_ok;

  assign req       = ui_in[3:0];
  assign hold      = ui_in[6];
  assign unused_ok = &{1'b0, ena, ui_in[7]};

  // Rotating priority search starting at ptr.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    cand  = ptr;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    idx_nx    = idx;
    op_nx     = op;
    a_nx      = a;
    b_nx      = b;
    result_nx = result;
    wd_nx     = wd;
    err_nx    = err;
    case (state)
      IDLE: begin
        if (!hold && found) begin
          idx_nx   = win;
          op_nx    = ui_in[5:4];
          a_nx     = uio_in[{win, 1'b0}];
          b_nx     = uio_in[{win, 1'b1}];
          state_nx = EXEC;
        end
      end
      EXEC: begin
        case (op)
          2'b00:   result_nx = a & b;
          2'b01:   result_nx = a | b;
          2'b10:   result_nx = a ^ b;
          default: result_nx = ~(a & b);
        endcase
        wd_nx    = 4'd0;
        state_nx = RESP;
      end
      RESP: begin
        if (!req[idx]) begin
          ptr_nx   = idx + 2'd1;
          state_nx = IDLE;
        end else if (wd == WD_MAX) begin
          // Requester never released: flag it and move on so others are not starved.
          err_nx   = 1'b1;
          ptr_nx   = idx + 2'd1;
          state_nx = IDLE;
        end else begin
          wd_nx = wd + 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= 2'd0;
      idx    <= 2'd0;
      op     <= 2'd0;
      a      <= 1'b0;
      b      <= 1'b0;
      result <= 1'b0;
      wd     <= 4'd0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      ptr    <= ptr_nx;
      idx    <= idx_nx;
      op     <= op_nx;
      a      <= a_nx;
      b      <= b_nx;
      result <= result_nx;
      wd     <= wd_nx;
      err    <= err_nx;
    end
  end

  // Outputs decode registered state only; nothing from the inputs reaches uo_out.
  assign uo_out[3:0] = (state == RESP) ? (4'b0001 << idx) : 4'b0000;
  assign uo_out[4]   = (state == RESP);
  assign uo_out[5]   = (state == RESP) & result;
  assign uo_out[6]   = (state != IDLE);
  assign uo_out[7]   = err;

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_tt_um_gate_arb.sv
// Testbench for tt_um_gate_arb: per-cycle vector table plus a watchdog sequence.
`default_nettype none

module tb_tt_um_gate_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_gate_arb dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [7:0] ui;
    logic [7:0] uio;
    logic [7:0] exp;
  } vec_t;

  vec_t       tbl[64];
  int         n_vec = 0;
  logic [7:0] sb_q[$];
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic add(input logic r, input logic [7:0] ui, input logic [7:0] uio,
                     input logic [7:0] exp);
    tbl[n_vec] = '{r, ui, uio, exp};
    n_vec++;
  endtask

  // Drive one cycle of inputs, queue the expected uo_out, then check after the edge.
  task automatic step(input string name, input logic r, input logic [7:0] ui,
                      input logic [7:0] uio, input logic [7:0] exp);
    logic [7:0] want;
    @(negedge clk);
    rst_n  = r;
    ui_in  = ui;
    uio_in = uio;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    want = sb_q.pop_front();
    n_checks++;
    if (uo_out !== want) begin
      n_fail++;
      $display("FAIL %s: uo_out=%h expected %h", name, uo_out, want);
    end
    n_checks++;
    if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
      n_fail++;
      $display("FAIL %s uio: uio_out=%h uio_oe=%h expected 00 00", name, uio_out, uio_oe);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // Basic AND grant, then release.
    add(0, 8'h00, 8'h00, 8'h00);
    add(1, 8'h01, 8'h03, 8'h40);
    add(1, 8'h01, 8'h03, 8'h71);
    add(1, 8'h00, 8'h03, 8'h00);
    // Round robin over all four with XOR.
    add(0, 8'h00, 8'h78, 8'h00);
    add(1, 8'h2F, 8'h78, 8'h40);
    add(1, 8'h2F, 8'h78, 8'h51);
    add(1, 8'h2E, 8'h78, 8'h00);
    add(1, 8'h2E, 8'h78, 8'h40);
    add(1, 8'h2E, 8'h78, 8'h72);
    add(1, 8'h2C, 8'h78, 8'h00);
    add(1, 8'h2C, 8'h78, 8'h40);
    add(1, 8'h2C, 8'h78, 8'h54);
    add(1, 8'h28, 8'h78, 8'h00);
    add(1, 8'h28, 8'h78, 8'h40);
    add(1, 8'h28, 8'h78, 8'h78);
    add(1, 8'h20, 8'h78, 8'h00);
    // Grant 2, then req=0101 must pick 0 (ptr wraps); req drop during EXEC.
    add(0, 8'h00, 8'h30, 8'h00);
    add(1, 8'h04, 8'h30, 8'h40);
    add(1, 8'h04, 8'h30, 8'h74);
    add(1, 8'h00, 8'h30, 8'h00);
    add(1, 8'h05, 8'h30, 8'h40);
    add(1, 8'h05, 8'h30, 8'h51);
    add(1, 8'h04, 8'h30, 8'h00);
    add(1, 8'h04, 8'h30, 8'h40);
    add(1, 8'h00, 8'h30, 8'h74);
    add(1, 8'h00, 8'h30, 8'h00);
    // Hold blocks arbitration only; in-flight work completes.
    add(0, 8'h00, 8'hFF, 8'h00);
    add(1, 8'h4F, 8'hFF, 8'h00);
    add(1, 8'h4F, 8'hFF, 8'h00);
    add(1, 8'h0F, 8'hFF, 8'h40);
    add(1, 8'h4F, 8'hFF, 8'h71);
    add(1, 8'h4E, 8'hFF, 8'h00);
    add(1, 8'h4E, 8'hFF, 8'h00);
    // Reset during RESP, then grant 3.
    add(0, 8'h00, 8'h0C, 8'h00);
    add(1, 8'h02, 8'h0C, 8'h40);
    add(1, 8'h02, 8'h0C, 8'h72);
    add(0, 8'h02, 8'h0C, 8'h00);
    add(1, 8'h08, 8'hC0, 8'h40);
    add(1, 8'h08, 8'hC0, 8'h78);
    add(1, 8'h00, 8'hC0, 8'h00);
    // OR, then NAND with operands/op changed during EXEC.
    add(0, 8'h00, 8'h01, 8'h00);
    add(1, 8'h11, 8'h01, 8'h40);
    add(1, 8'h11, 8'h01, 8'h71);
    add(1, 8'h30, 8'h03, 8'h00);
    add(1, 8'h31, 8'h03, 8'h40);
    add(1, 8'h01, 8'h00, 8'h51);
    add(1, 8'h30, 8'h00, 8'h00);

    for (int i = 0; i < n_vec; i++)
      step($sformatf("vec%0d", i), tbl[i].rst_n, tbl[i].ui, tbl[i].uio, tbl[i].exp);

    // Stuck requester 1: 16 valid cycles, then err, IDLE, re-grant.
    step("wd_rst", 0, 8'h00, 8'h0C, 8'h00);
    step("wd_exec", 1, 8'h02, 8'h0C, 8'h40);
    for (int i = 0; i < 16; i++)
      step($sformatf("wd_resp%0d", i), 1, 8'h02, 8'h0C, 8'h72);
    step("wd_err_idle", 1, 8'h02, 8'h0C, 8'h80);
    step("wd_regrant_exec", 1, 8'h02, 8'h0C, 8'hC0);
    step("wd_regrant_resp", 1, 8'h02, 8'h0C, 8'hF2);
    step("wd_release", 1, 8'h00, 8'h0C, 8'h80);
    step("wd_sticky", 1, 8'h00, 8'h0C, 8'h80);
    step("wd_clear", 0, 8'h00, 8'h0C, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
